// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: FSM encoding, maximal-length XNOR tap masks and
// the lock-up constant that an XNOR LFSR can never leave.
package lfsr_pkg;

  typedef enum logic [1:0] {StIdle, StSeed, StStep, StDeliver} lfsr_state_e;

  localparam int unsigned MaxBits = 32;

  // Bit i set means register bit i (0-based) feeds the XNOR.
  function automatic logic [MaxBits-1:0] lfsr_taps(int unsigned num_bits);
    logic [MaxBits-1:0] mask;
    case (num_bits)
      3:       mask = 32'h0000_0006;
      4:       mask = 32'h0000_000C;
      5:       mask = 32'h0000_0014;
      6:       mask = 32'h0000_0030;
      7:       mask = 32'h0000_0060;
      8:       mask = 32'h0000_00B8;
      9:       mask = 32'h0000_0110;
      10:      mask = 32'h0000_0240;
      11:      mask = 32'h0000_0500;
      12:      mask = 32'h0000_0829;
      13:      mask = 32'h0000_100D;
      14:      mask = 32'h0000_2015;
      15:      mask = 32'h0000_6000;
      16:      mask = 32'h0000_D008;
      17:      mask = 32'h0001_2000;
      18:      mask = 32'h0002_0400;
      19:      mask = 32'h0004_0023;
      20:      mask = 32'h0009_0000;
      21:      mask = 32'h0014_0000;
      22:      mask = 32'h0030_0000;
      23:      mask = 32'h0042_0000;
      24:      mask = 32'h00E1_0000;
      25:      mask = 32'h0120_0000;
      26:      mask = 32'h0200_0023;
      27:      mask = 32'h0400_0013;
      28:      mask = 32'h0900_0000;
      29:      mask = 32'h1400_0000;
      30:      mask = 32'h2000_0029;
      31:      mask = 32'h4800_0000;
      32:      mask = 32'h8020_0003;
      default: mask = '0;
    endcase
    return mask;
  endfunction

  function automatic logic [MaxBits-1:0] lock_up_value(int unsigned num_bits);
    return {MaxBits{1'b1}} >> (MaxBits - num_bits);
  endfunction

endpackage

// File: rtl/lfsr_arbiter_core.sv
// XNOR-feedback shift register; load wins over step. next_o is the value the
// register takes on a step, exposed so the parent can register it early.
module lfsr_arbiter_core
  import lfsr_pkg::*;
#(
  parameter int unsigned NumBits = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               step_i,
  input  logic               load_i,
  input  logic [NumBits-1:0] load_data_i,
  output logic [NumBits-1:0] state_o,
  output logic [NumBits-1:0] next_o
);

  localparam logic [NumBits-1:0] Taps = NumBits'(lfsr_taps(NumBits));

  logic [NumBits-1:0] lfsr_q, lfsr_d;

  assign next_o  = {lfsr_q[NumBits-2:0], ~^(lfsr_q & Taps)};
  assign state_o = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_data_i;
    end else if (step_i) begin
      lfsr_d = next_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/lfsr_arbiter.sv
// Round-robin sharing of one XNOR LFSR: each grant shifts STEPS_PER_GRANT
// times and delivers the word, with seed loading and period-wrap detection.
module lfsr_arbiter
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_BITS        = 16,
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned STEPS_PER_GRANT = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic [NUM_REQ-1:0]  i_Req,
  output logic [NUM_REQ-1:0]  o_Gnt,
  output logic [NUM_BITS-1:0] o_Data,
  output logic                o_Valid,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic                o_Seed_Err,
  output logic                o_Wrap,
  output logic                o_Busy
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned IdxW1 = IdxW + 1;
  localparam int unsigned CntW  = $clog2(STEPS_PER_GRANT + 1);
  localparam logic [NUM_BITS-1:0] LockUp  = NUM_BITS'(lock_up_value(NUM_BITS));
  localparam logic [CntW-1:0]     LastCnt = CntW'(STEPS_PER_GRANT - 1);
  localparam logic [IdxW-1:0]     LastIdx = IdxW'(NUM_REQ - 1);

  lfsr_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic [NUM_BITS-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                valid_q, valid_d;
  logic                seed_err_q, seed_err_d;
  logic                wrap_q, wrap_d;
  logic                busy_q, busy_d;

  logic                step, load;
  logic [NUM_BITS-1:0] load_data, lfsr_state, lfsr_next;
  logic [IdxW-1:0]     rr_idx;
  logic [IdxW1-1:0]    cand;

  lfsr_arbiter_core #(
    .NumBits(NUM_BITS)
  ) u_core (
    .clk_i      (i_Clk),
    .rst_ni     (i_Rst_n),
    .step_i     (step),
    .load_i     (load),
    .load_data_i(load_data),
    .state_o    (lfsr_state),
    .next_o     (lfsr_next)
  );

  // Scan from the far end so the nearest requester at/after rr_ptr wins last.
  always_comb begin
    rr_idx = rr_ptr_q;
    cand   = '0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + IdxW1'(k);
      if (cand >= IdxW1'(NUM_REQ)) begin
        cand = cand - IdxW1'(NUM_REQ);
      end
      if (i_Req[cand[IdxW-1:0]]) begin
        rr_idx = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    seed_d     = seed_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    gnt_d      = '0;
    seed_err_d = 1'b0;
    step       = 1'b0;
    load       = 1'b0;
    load_data  = i_Seed_Data;

    unique case (state_q)
      StIdle: begin
        if (i_Seed_DV) begin
          state_d = StSeed;
          load    = 1'b1;
          if (i_Seed_Data == LockUp) begin
            load_data  = '0;
            seed_err_d = 1'b1;
          end
          seed_d = load_data;
        end else if (|i_Req) begin
          gnt_idx_d = rr_idx;
          cnt_d     = '0;
          state_d   = StStep;
        end
      end
      StSeed: state_d = StIdle;
      StStep: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // Outputs are registered, so capture the final shift result here.
        if (cnt_q == LastCnt) begin
          state_d           = StDeliver;
          data_d            = lfsr_next;
          valid_d           = 1'b1;
          gnt_d[gnt_idx_q]  = 1'b1;
        end
      end
      StDeliver: begin
        rr_ptr_d = (gnt_idx_q == LastIdx) ? '0 : gnt_idx_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    wrap_d = step && (lfsr_next == seed_q);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      seed_q     <= '0;
      data_q     <= '0;
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      seed_err_q <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      seed_q     <= seed_d;
      data_q     <= data_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      seed_err_q <= seed_err_d;
      wrap_q     <= wrap_d;
      busy_q     <= busy_d;
    end
  end

  assign o_Gnt      = gnt_q;
  assign o_Data     = data_q;
  assign o_Valid    = valid_q;
  assign o_Seed_Err = seed_err_q;
  assign o_Wrap     = wrap_q;
  assign o_Busy     = busy_q;

endmodule
